// File: rtl/hex_pkg.sv
// Shared constants and helpers for the hex display path.
package hex_pkg;

    localparam int DISP_W   = 16;
    localparam int NIBBLE_W = 4;

    localparam logic [3:0] SEL_D3 = 4'b1000;
    localparam logic [3:0] SEL_D2 = 4'b0100;
    localparam logic [3:0] SEL_D1 = 4'b0010;
    localparam logic [3:0] SEL_D0 = 4'b0001;

    // Bit position of a one-hot select (1000 -> 3 ... 0001 -> 0).
    function automatic logic [1:0] sel_index(input logic [3:0] sel);
        logic [1:0] idx;
        case (sel)
            SEL_D2:  idx = 2'd2;
            SEL_D1:  idx = 2'd1;
            SEL_D0:  idx = 2'd0;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Next digit to the right, wrapping 0001 back to 1000.
    function automatic logic [3:0] rotate_sel(input logic [3:0] sel);
        return {sel[0], sel[3:1]};
    endfunction

endpackage

// File: rtl/digit_scanner_if.sv
// Word-input handshake plus the (select, data) display bus.
interface digit_scanner_if;
    import hex_pkg::*;

    logic [DISP_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        digit_en;
    logic [3:0]        select;
    logic [DISP_W-1:0] data;
    logic              blank;
    logic              frame_start;

    // Producer of display words and digit enables.
    modport master (
        output in_data, in_valid, digit_en,
        input  in_ready, select, data, blank, frame_start
    );

    // The scanner itself.
    modport slave (
        input  in_data, in_valid, digit_en,
        output in_ready, select, data, blank, frame_start
    );

endinterface

// File: rtl/digit_scanner_scan_timer.sv
// Slot timer: counts clocks within a digit slot and flags the blanking window.
module scan_timer #(
    parameter int DIGIT_CYCLES = 16384,
    parameter int BLANK_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,   // counter is on the last clock of the slot
    output logic in_blank    // next-state counter falls inside the blanking window
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // Next counter value and the flags derived from it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        slot_end   = 1'b0;
        count_next = count + 1'b1;
        if (count == LAST) begin
            slot_end   = 1'b1;
            count_next = '0;
        end
        in_blank = (count_next < BLANK);
    end

    // Slot counter register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so each register samples pre-edge values.
        if (rst) count <= '0;
        else     count <= count_next;
    end

endmodule

// File: rtl/digit_scanner.sv
// Four-digit scanner: rotates the select, blanks during slot start, and commits
// new display words only at frame boundaries so the display never tears.
module digit_scanner
    import hex_pkg::*;
#(
    parameter int DIGIT_CYCLES = 16384,
    parameter int BLANK_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    digit_scanner_if.slave bus
);

    logic              slot_end;
    logic              in_blank;

    logic [3:0]        sel_q;
    logic [3:0]        sel_next;
    logic [DISP_W-1:0] data_q;
    logic [DISP_W-1:0] pend_q;
    logic              pend_full;
    logic              ready_q;
    logic              blank_q;
    logic              fs_q;

    logic              wrap;
    logic              accept;
    logic              commit;
    logic              blank_next;

    scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    // Next select, frame wrap, handshake and blanking decisions.
    always_comb begin
        sel_next   = slot_end ? rotate_sel(sel_q) : sel_q;
        wrap       = slot_end && (sel_q == SEL_D0);
        accept     = bus.in_valid && ready_q;
        commit     = wrap && pend_full;
        blank_next = in_blank || !bus.digit_en[sel_index(sel_next)];
    end

    // Select rotation, blanking and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= SEL_D3;
            blank_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            sel_q   <= sel_next;
            blank_q <= blank_next;
            fs_q    <= wrap;
        end
    end

    // Pending buffer, commit at frame wrap, and input ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            pend_full <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            if (accept) begin
                pend_full <= 1'b1;
                ready_q   <= 1'b0;
            end else begin
                // Ready returns one cycle after the buffer drains.
                ready_q <= !pend_full;
                if (commit) begin
                    data_q    <= pend_q;
                    pend_full <= 1'b0;
                end
            end
        end
    end

    // Pending word storage.
    always_ff @(posedge clk) begin
        // NOTE: the word register has no reset; pend_full guards it, so a stale value is never committed.
        if (accept) pend_q <= bus.in_data;
    end

    assign bus.select      = sel_q;
    assign bus.data        = data_q;
    assign bus.blank       = blank_q;
    assign bus.in_ready    = ready_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_digit_scanner;
    import hex_pkg::*;

    localparam int DC = 8;
    localparam int BC = 2;

    typedef struct {
        logic [15:0] word;
        int          vis;    // first cycle the word sits in the pending buffer
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    digit_scanner_if bus();

    digit_scanner #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    sb_t         sb_q[$];
    int          total    = 0;
    int          bad      = 0;
    int          cyc      = 0;
    logic [15:0] exp_data = '0;
    logic [3:0]  en_edge  = 4'b1111;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Compare all display outputs against the cycle-position model.
    task automatic check_outputs();
        int         off;
        int         slot;
        logic [3:0] exp_sel;
        logic       exp_blank;
        logic       exp_fs;
        off       = cyc % DC;
        slot      = (cyc / DC) % 4;
        exp_sel   = 4'b1000 >> slot;
        exp_blank = (off < BC) || !en_edge[3 - slot];
        exp_fs    = (cyc > 0) && (cyc % (4 * DC) == 0);
        check("select",      16'(bus.select),      16'(exp_sel));
        check("blank",       16'(bus.blank),       16'(exp_blank));
        check("frame_start", 16'(bus.frame_start), 16'(exp_fs));
        check("data",        bus.data,             exp_data);
    endtask

    // Advance one clock, update the scoreboard, then check outputs.
    task automatic tick();
        logic r;
        sb_t  e;
        r = rst;
        if (!r && (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1))
            sb_q.push_back('{word: bus.in_data, vis: cyc + 1});
        en_edge = bus.digit_en;
        @(posedge clk);
        #1;
        if (r) begin
            cyc      = 0;
            exp_data = '0;
            sb_q.delete();
        end else begin
            cyc++;
            if ((cyc % (4 * DC) == 0) && (sb_q.size() > 0) && (sb_q[0].vis < cyc)) begin
                e        = sb_q.pop_front();
                exp_data = e.word;
            end
        end
        check_outputs();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.digit_en = 4'b1111;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("ready_reset", 16'(bus.in_ready), 16'h0001);
        rst = 1'b0;

        // First word accepted in cycle 5
        run_to(5);
        check("ready_c5", 16'(bus.in_ready), 16'h0001);
        bus.in_data  = 16'hABCD;
        bus.in_valid = 1'b1;
        tick();
        check("ready_c6", 16'(bus.in_ready), 16'h0000);

        // Back-pressure: 1234 held valid while the buffer is full
        bus.in_data = 16'h1234;
        run_to(31);
        check("ready_c31", 16'(bus.in_ready), 16'h0000);
        tick();
        check("data_c32",  bus.data,              16'hABCD);
        check("ready_c32", 16'(bus.in_ready), 16'h0000);
        tick();
        check("ready_c33", 16'(bus.in_ready), 16'h0001);
        tick();
        bus.in_valid = 1'b0;
        check("ready_c34", 16'(bus.in_ready), 16'h0000);

        // Digit 0100 disabled for the next frame
        run_to(63);
        bus.digit_en = 4'b1011;
        tick();
        check("data_c64", bus.data, 16'h1234);
        run_to(75);
        check("blank_masked_c75", 16'(bus.blank), 16'h0001);

        // Word accepted in the wrap cycle waits a full frame
        run_to(95);
        bus.digit_en = 4'b1111;
        check("ready_c95", 16'(bus.in_ready), 16'h0001);
        bus.in_data  = 16'h5A5A;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("data_c96",  bus.data,              16'h1234);
        check("ready_c96", 16'(bus.in_ready), 16'h0000);
        run_to(128);
        check("data_c128", bus.data, 16'h5A5A);

        // Reset mid-slot with 9999 pending
        tick();
        check("ready_c129", 16'(bus.in_ready), 16'h0001);
        bus.in_data  = 16'h9999;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("ready_c130", 16'(bus.in_ready), 16'h0000);
        run_to(147);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("select_after_rst", 16'(bus.select),   16'(SEL_D3));
        check("blank_after_rst",  16'(bus.blank),    16'h0001);
        check("data_after_rst",   bus.data,              16'h0000);
        check("ready_after_rst",  16'(bus.in_ready), 16'h0001);

        // Idle frame after reset: 9999 never appears
        run_to(40);
        check("data_idle_c40", bus.data, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
